// File: rtl/vline_filter_3tap.sv
// -----------------------------------------------------------------------------
// vline_filter_3tap
//   Vertical 3-tap filter for the video display path. Two internal line
//   memories hold line n-1 (L1) and line n-2 (L2). Each output pixel, per
//   channel, is the bypassed pixel, the pixel from the line above, the rounded
//   2-tap average, or the rounded [1 2 1]/4 blend. Frame-top lines replicate
//   the current line so that no stale memory content leaks into the output.
//
// Ports
//   iCLK         in   pixel clock, all logic on the rising edge
//   iRST_N       in   asynchronous active-low reset
//   iSOF         in   start-of-frame pulse (1 cycle)
//   iDVAL        in   input pixel valid
//   iData        in   CHANNELS*DATA_W pixel word, channel 0 in the LSBs
//   iMode        in   0 bypass, 1 line repeat, 2 avg2, 3 tap121
//   oData        out  filtered pixel word (holds while oDVAL=0)
//   oDVAL        out  oData valid, iDVAL delayed by exactly 2 cycles
//   oLines_Seen  out  completed lines in this frame, saturating at 2
// -----------------------------------------------------------------------------
module vline_filter_3tap #(
  parameter int DATA_W   = 8,
  parameter int CHANNELS = 2,
  parameter int LINE_PIX = 640,
  parameter int COL_W    = 10
) (
  input  logic                       iCLK,
  input  logic                       iRST_N,
  input  logic                       iSOF,
  input  logic                       iDVAL,
  input  logic [CHANNELS*DATA_W-1:0] iData,
  input  logic [1:0]                 iMode,
  output logic [CHANNELS*DATA_W-1:0] oData,
  output logic                       oDVAL,
  output logic [1:0]                 oLines_Seen
);

  localparam int PIX_W = CHANNELS * DATA_W;

  // Rounded right shift on the widened accumulator: adds half an LSB of the
  // result before shifting.
  function automatic logic [DATA_W+1:0] rnd_shr(input logic [DATA_W+1:0] sum,
                                                input int unsigned       sh);
    logic [DATA_W+1:0] half;
    half = (DATA_W+2)'(1) << (sh - 1);
    return (sum + half) >> sh;
  endfunction

  // One channel of the filter including frame-top replication. The DATA_W+2
  // accumulator holds 4*max+2 without overflow, so no saturation is needed.
  function automatic logic [DATA_W-1:0] blend(input logic [1:0]        mode,
                                              input logic [1:0]        lines,
                                              input logic [DATA_W-1:0] cur,
                                              input logic [DATA_W-1:0] a1_raw,
                                              input logic [DATA_W-1:0] a2_raw);
    logic [DATA_W+1:0] c, a1, a2, acc;
    c  = {2'b00, cur};
    a1 = (lines == 2'd0) ? c : {2'b00, a1_raw};
    a2 = (lines == 2'd0) ? c : ((lines == 2'd1) ? a1 : {2'b00, a2_raw});
    case (mode)
      2'd0:    acc = c;
      2'd1:    acc = a1;
      2'd2:    acc = rnd_shr(c + a1, 1);
      default: acc = rnd_shr(a2 + (a1 << 1) + c, 2);
    endcase
    return acc[DATA_W-1:0];
  endfunction

  // Frame/line control state
  logic [COL_W-1:0] col_q, col_d, col_base;
  logic [1:0]       lines_q, lines_d, lines_base;
  logic [1:0]       mode_q, mode_d, mode_base;

  // iSOF takes effect before a same-cycle pixel, so that pixel lands in col 0
  // of the new frame with the freshly latched mode.
  always_comb begin
    col_base   = iSOF ? '0    : col_q;
    lines_base = iSOF ? 2'd0  : lines_q;
    mode_base  = iSOF ? iMode : mode_q;
    col_d      = col_base;
    lines_d    = lines_base;
    mode_d     = mode_base;
    if (iDVAL) begin
      if (col_base == COL_W'(LINE_PIX - 1)) begin
        col_d   = '0;
        lines_d = (lines_base == 2'd2) ? 2'd2 : lines_base + 2'd1;
        mode_d  = iMode;
      end else begin
        col_d = col_base + 1'b1;
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      col_q   <= '0;
      lines_q <= 2'd0;
      mode_q  <= 2'd0;
    end else begin
      col_q   <= col_d;
      lines_q <= lines_d;
      mode_q  <= mode_d;
    end
  end

  // Line memories and stage-1 capture
  logic [PIX_W-1:0] l1_mem [LINE_PIX];
  logic [PIX_W-1:0] l2_mem [LINE_PIX];
  logic [PIX_W-1:0] cur_p1, a1_p1, a2_p1;
  logic [1:0]       lines_p1, mode_p1;
  logic             vld_p1;

  // Reads return the pre-write contents; the memories are never cleared
  // because frame-top replication masks anything stale.
  always_ff @(posedge iCLK) begin
    if (iDVAL) begin
      l2_mem[col_base] <= l1_mem[col_base];
      l1_mem[col_base] <= iData;
      cur_p1           <= iData;
      a1_p1            <= l1_mem[col_base];
      a2_p1            <= l2_mem[col_base];
      lines_p1         <= lines_base;
      mode_p1          <= mode_base;
    end
  end

  // Stage 2: per-channel blend, registered onto the output
  logic [PIX_W-1:0] filt_d;
  logic [PIX_W-1:0] data_p2;
  logic             vld_p2;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    assign filt_d[c*DATA_W +: DATA_W] = blend(mode_p1, lines_p1,
                                              cur_p1[c*DATA_W +: DATA_W],
                                              a1_p1[c*DATA_W +: DATA_W],
                                              a2_p1[c*DATA_W +: DATA_W]);
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      data_p2 <= '0;
    end else begin
      vld_p1 <= iDVAL;
      vld_p2 <= vld_p1;
      if (vld_p1) data_p2 <= filt_d;
    end
  end

  assign oData       = data_p2;
  assign oDVAL       = vld_p2;
  assign oLines_Seen = lines_q;

endmodule

// File: tb/tb_vline_filter_3tap.sv
module tb_vline_filter_3tap;

  localparam int DATA_W   = 8;
  localparam int CHANNELS = 2;
  localparam int LINE_PIX = 4;
  localparam int COL_W    = 2;
  localparam int PIX_W    = DATA_W * CHANNELS;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             sof;
  logic             dval;
  logic [PIX_W-1:0] din;
  logic [1:0]       mode;
  logic [PIX_W-1:0] o_data;
  logic             o_dval;
  logic [1:0]       o_lines;

  vline_filter_3tap #(
    .DATA_W(DATA_W), .CHANNELS(CHANNELS), .LINE_PIX(LINE_PIX), .COL_W(COL_W)
  ) dut (
    .iCLK(clk), .iRST_N(rst_n), .iSOF(sof), .iDVAL(dval), .iData(din),
    .iMode(mode), .oData(o_data), .oDVAL(o_dval), .oLines_Seen(o_lines)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [PIX_W-1:0] data;
    int               cyc;
  } exp_t;

  exp_t             sb_q[$];
  int               n_checks = 0;
  int               n_fail   = 0;
  logic [PIX_W-1:0] last_exp = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic record_fail(input string name, input int act, input int exp);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // One pixel; the expected output is due 2 cycles after the drive cycle.
  task automatic pix(input logic [PIX_W-1:0] d, input logic push, input logic [PIX_W-1:0] e);
    exp_t x;
    din  = d;
    dval = 1'b1;
    if (push) begin
      x.data = e;
      x.cyc  = cyc + 2;
      sb_q.push_back(x);
    end
    @(posedge clk); #1;
    dval = 1'b0;
    sof  = 1'b0;
    din  = 16'hDEAD;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Constant-valued line; iMode switches from m0 to m2 at column 2.
  task automatic send_line(input logic [PIX_W-1:0] d, input logic [PIX_W-1:0] e,
                           input logic s, input logic [1:0] m0, input logic [1:0] m2,
                           input int maxgap);
    for (int c = 0; c < LINE_PIX; c++) begin
      sof  = (c == 0) ? s : 1'b0;
      mode = (c >= 2) ? m2 : m0;
      pix(d, 1'b1, e);
      if (maxgap > 0) idle($urandom_range(maxgap, 0));
    end
  endtask

  task automatic drain();
    int budget = 40;
    while (sb_q.size() > 0 && budget > 0) begin
      idle(1);
      budget--;
    end
    if (sb_q.size() > 0) record_fail("drain_timeout", sb_q.size(), 0);
  endtask

  // Scoreboard monitor, sampling away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) last_exp = '0;
      if (o_dval) begin
        if (sb_q.size() == 0) begin
          record_fail("unexpected_dval", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("odata", 32'(o_data), 32'(e.data));
          check("latency", 32'(cyc), 32'(e.cyc));
          last_exp = e.data;
        end
      end else begin
        check("hold", 32'(o_data), 32'(last_exp));
        if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
          e = sb_q.pop_front();
          record_fail("missing_dval", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    sof   = 1'b0;
    dval  = 1'b0;
    din   = '0;
    mode  = 2'd0;
    idle(3);
    check("rst_odval", 32'(o_dval), 32'd0);
    check("rst_odata", 32'(o_data), 32'd0);
    check("rst_lines", 32'(o_lines), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // tap121 with frame-top replication; ch1 checks a second channel
    send_line(16'h8010, 16'h8010, 1'b1, 2'd3, 2'd3, 0);
    check("lines_after_l0", 32'(o_lines), 32'd1);
    send_line(16'h4020, 16'h7014, 1'b0, 2'd3, 2'd3, 0);
    check("lines_after_l1", 32'(o_lines), 32'd2);
    send_line(16'h0040, 16'h4024, 1'b0, 2'd3, 2'd3, 0);
    check("lines_saturate", 32'(o_lines), 32'd2);
    drain();

    // avg2 rounding; ch1 at full scale checks no overflow
    send_line(16'hFF01, 16'hFF01, 1'b1, 2'd2, 2'd2, 0);
    check("sof_clears_lines", 32'(o_lines), 32'd1);
    send_line(16'hFF02, 16'hFF02, 1'b0, 2'd2, 2'd2, 0);
    drain();

    // line repeat
    send_line(16'h33AA, 16'h33AA, 1'b1, 2'd1, 2'd1, 0);
    send_line(16'hCC55, 16'h33AA, 1'b0, 2'd1, 2'd1, 0);
    drain();

    // mid-line mode change only takes effect on the next line
    send_line(16'h1234, 16'h1234, 1'b1, 2'd0, 2'd0, 0);
    send_line(16'h5678, 16'h5678, 1'b0, 2'd0, 2'd3, 0);
    send_line(16'h0000, 16'h3049, 1'b0, 2'd3, 2'd3, 0);
    drain();

    // random iDVAL gaps must not change the results
    send_line(16'h8010, 16'h8010, 1'b1, 2'd3, 2'd3, 3);
    send_line(16'h4020, 16'h7014, 1'b0, 2'd3, 2'd3, 3);
    send_line(16'h0040, 16'h4024, 1'b0, 2'd3, 2'd3, 3);
    drain();

    // asynchronous reset in mid-line
    sof  = 1'b1;
    mode = 2'd0;
    pix(16'h1111, 1'b1, 16'h1111);
    pix(16'h2222, 1'b0, 16'h0000);
    pix(16'h3333, 1'b0, 16'h0000);
    rst_n = 1'b0;
    #1;
    check("async_rst_odval", 32'(o_dval), 32'd0);
    check("async_rst_odata", 32'(o_data), 32'd0);
    check("async_rst_lines", 32'(o_lines), 32'd0);
    idle(3);
    rst_n = 1'b1;
    idle(2);
    send_line(16'h4321, 16'h4321, 1'b1, 2'd3, 2'd3, 0);
    drain();
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
